// File: rtl/control_fsm.sv
//------------------------------------------------------------------------------
// control_fsm
// Multicycle CPU control FSM: Moore state machine that sequences fetch, decode,
// memory access, ALU execute and branch, and counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps until reset).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        PCSource,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUop,
  output logic [3:0]  state,
  output logic [15:0] instr_count,
  output logic        illegal
);

  localparam logic [6:0] c_OP_LD  = 7'b0000011;
  localparam logic [6:0] c_OP_SB  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_EXECI   = 4'd9,
    S_TRAP    = 4'd15
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr_count;
  logic        w_retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_instr_count <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively while the opcode is decoded.
        ALUSrcB = 2'b11;
        case (opcode)
          c_OP_LD, c_OP_SB: w_next = S_MEMADDR;
          c_OP_R:           w_next = S_EXEC;
          c_OP_I:           w_next = S_EXECI;
          c_OP_BEQ:         w_next = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == c_OP_SB) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = 2'b11;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset silences the datapath immediately, not just from the next edge.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
//------------------------------------------------------------------------------
// tb_control_fsm
// Scoreboard bench for control_fsm: directed per-cycle expectations are queued
// by the stimulus process and checked by an independent negedge monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, ALUSrcA, PCSource, RegWrite;
  logic [1:0]  ALUSrcB, ALUop;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        illegal;

  control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .PCSource(PCSource),
    .RegWrite(RegWrite), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .state(state), .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,PCSource,RegWrite,ALUSrcB,ALUop}
  wire [13:0] w_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, ALUSrcA, PCSource, RegWrite, ALUSrcB, ALUop};

  localparam logic [13:0] C_ZERO    = 14'b0_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_FETCH1  = 14'b1_0_0_1_0_0_1_0_0_0_01_00;
  localparam logic [13:0] C_FETCH0  = 14'b0_0_0_1_0_0_0_0_0_0_01_00;
  localparam logic [13:0] C_DECODE  = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [13:0] C_MEMADDR = 14'b0_0_0_0_0_0_0_1_0_0_10_00;
  localparam logic [13:0] C_MEMRD   = 14'b0_0_1_1_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_MEMWB   = 14'b0_0_0_0_0_1_0_0_0_1_00_00;
  localparam logic [13:0] C_MEMWR   = 14'b0_0_1_0_1_0_0_0_0_0_00_00;
  localparam logic [13:0] C_EXEC    = 14'b0_0_0_0_0_0_0_1_0_0_00_10;
  localparam logic [13:0] C_EXECI   = 14'b0_0_0_0_0_0_0_1_0_0_10_11;
  localparam logic [13:0] C_ALUWB   = 14'b0_0_0_0_0_0_0_0_0_1_00_00;
  localparam logic [13:0] C_BRANCH  = 14'b0_1_0_0_0_0_0_1_1_0_00_01;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SB  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [15:0] cnt;
    logic        ill;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] c0;

  // One clock cycle: drive inputs just after the edge and queue the outputs
  // expected for the rest of that cycle.
  task automatic cyc(input logic [6:0] op, input logic mr, input logic rst,
                     input logic [3:0] st, input logic [13:0] ctl,
                     input logic [15:0] cnt, input logic ill, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    reset     = rst;
    e.st = st; e.ctl = ctl; e.cnt = cnt; e.ill = ill; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: the FSM presents a new output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (state !== e.st) begin
          n_fail++;
          $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
        end
        n_tests++;
        if (w_ctl !== e.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b expected %b", e.nm, w_ctl, e.ctl);
        end
        n_tests++;
        if (instr_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s instr_count: got %h expected %h", e.nm, instr_count, e.cnt);
        end
        n_tests++;
        if (illegal !== e.ill) begin
          n_fail++;
          $display("FAIL %s illegal: got %b expected %b", e.nm, illegal, e.ill);
        end
      end
    end
  end

  initial begin
    #(10 * 400000);
    $display("FAIL timeout: simulation did not complete, %0d checks queued", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and first fetch
    cyc(7'd0,   0, 1, 4'd0, C_ZERO,    16'd0, 0, "reset");
    cyc(OP_LD,  1, 0, 4'd0, C_FETCH1,  16'd0, 0, "ld fetch");
    cyc(OP_LD,  1, 0, 4'd1, C_DECODE,  16'd0, 0, "ld decode");
    cyc(OP_LD,  1, 0, 4'd2, C_MEMADDR, 16'd0, 0, "ld memaddr");
    cyc(OP_LD,  1, 0, 4'd3, C_MEMRD,   16'd0, 0, "ld memrd");
    cyc(OP_LD,  1, 0, 4'd4, C_MEMWB,   16'd0, 0, "ld memwb");
    // sb with a 3-cycle memory stall
    cyc(OP_SB,  1, 0, 4'd0, C_FETCH1,  16'd1, 0, "sb fetch");
    cyc(OP_SB,  1, 0, 4'd1, C_DECODE,  16'd1, 0, "sb decode");
    cyc(OP_SB,  0, 0, 4'd2, C_MEMADDR, 16'd1, 0, "sb memaddr");
    cyc(OP_SB,  0, 0, 4'd5, C_MEMWR,   16'd1, 0, "sb memwr stall1");
    cyc(OP_SB,  0, 0, 4'd5, C_MEMWR,   16'd1, 0, "sb memwr stall2");
    cyc(OP_SB,  0, 0, 4'd5, C_MEMWR,   16'd1, 0, "sb memwr stall3");
    cyc(OP_SB,  1, 0, 4'd5, C_MEMWR,   16'd1, 0, "sb memwr done");
    // Fetch stall, then beq
    cyc(OP_BEQ, 0, 0, 4'd0, C_FETCH0,  16'd2, 0, "fetch stall");
    cyc(OP_BEQ, 1, 0, 4'd0, C_FETCH1,  16'd2, 0, "beq fetch");
    cyc(OP_BEQ, 1, 0, 4'd1, C_DECODE,  16'd2, 0, "beq decode");
    cyc(OP_BEQ, 1, 0, 4'd8, C_BRANCH,  16'd2, 0, "beq branch");
    // R-type and I-type
    cyc(OP_R,   1, 0, 4'd0, C_FETCH1,  16'd3, 0, "r fetch");
    cyc(OP_R,   1, 0, 4'd1, C_DECODE,  16'd3, 0, "r decode");
    cyc(OP_R,   1, 0, 4'd6, C_EXEC,    16'd3, 0, "r exec");
    cyc(OP_R,   1, 0, 4'd7, C_ALUWB,   16'd3, 0, "r aluwb");
    cyc(OP_I,   1, 0, 4'd0, C_FETCH1,  16'd4, 0, "i fetch");
    cyc(OP_I,   1, 0, 4'd1, C_DECODE,  16'd4, 0, "i decode");
    cyc(OP_I,   1, 0, 4'd9, C_EXECI,   16'd4, 0, "i execi");
    cyc(OP_I,   1, 0, 4'd7, C_ALUWB,   16'd4, 0, "i aluwb");
    // Illegal opcode
    cyc(OP_BAD, 1, 0, 4'd0, C_FETCH1,  16'd5, 0, "bad fetch");
    cyc(OP_BAD, 1, 0, 4'd1, C_DECODE,  16'd5, 0, "bad decode");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cyc(OP_BAD, 1, 0, 4'd15, C_ZERO, 16'd5, 1, "trap hold");
    end
    cyc(7'd0,   1, 1, 4'd15, C_ZERO,   16'd5, 1, "trap reset asserted");
    cyc(OP_LD,  1, 0, 4'd0,  C_FETCH1, 16'd0, 0, "trap released");
    c0 = 16'd0;
`else
    cyc(OP_LD,  1, 0, 4'd0, C_FETCH1,  16'd5, 0, "bad as nop");
    c0 = 16'd5;
`endif
    // Reset in the middle of a stalled load
    cyc(OP_LD,  1, 0, 4'd1, C_DECODE,  c0, 0, "rst-ld decode");
    cyc(OP_LD,  0, 0, 4'd2, C_MEMADDR, c0, 0, "rst-ld memaddr");
    cyc(OP_LD,  0, 0, 4'd3, C_MEMRD,   c0, 0, "rst-ld memrd stall");
    cyc(OP_LD,  0, 1, 4'd3, C_ZERO,    c0, 0, "reset in memrd");
    cyc(OP_R,   1, 0, 4'd0, C_FETCH1,  16'd0, 0, "post reset fetch");
    // 65535 R-type instructions at 4 cycles each bring the count to 0xFFFF
    repeat (4 * 65535 - 1) @(posedge clk);
    cyc(OP_R,   1, 0, 4'd0, C_FETCH1,  16'hFFFF, 0, "count ffff");
    cyc(OP_R,   1, 0, 4'd1, C_DECODE,  16'hFFFF, 0, "wrap decode");
    cyc(OP_R,   1, 0, 4'd6, C_EXEC,    16'hFFFF, 0, "wrap exec");
    cyc(OP_R,   1, 0, 4'd7, C_ALUWB,   16'hFFFF, 0, "wrap aluwb");
    cyc(OP_R,   1, 0, 4'd0, C_FETCH1,  16'h0000, 0, "count wrap");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  `IR[6:0]`, valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, PCSource, RegWrite  output  1 each  datapath strobes and selects.
REQ-007 ALUSrcB  output  2  ALU B select: 00 = reg, 01 = const 4, 10 = imm, 11 = imm shifted for the branch target.
REQ-008 ALUop  output  2  feeds the ALU-control stage: 00 = add, 01 = sub (beq), 10 = R-type (funct decides), 11 = I-type ALU.
REQ-009 state  output  4  current state, for debug.
REQ-010 instr_count  output  16  count of retired instructions.
REQ-011 illegal  output  1  illegal opcode seen; present only when ILLEGAL_TRAP_EN is defined, otherwise tied 0.

Function
REQ-012 The block SHALL be a Moore FSM. State encoding:
- FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4
- MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, EXECI = 9, TRAP = 15.

REQ-013 In FETCH the block SHALL drive MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUop = 00, PCSource = 0.
- IRWrite = PCWrite = mem_ready.
- Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.

REQ-014 In DECODE the block SHALL drive ALUSrcA = 0, ALUSrcB = 11, ALUop = 00, then branch on opcode:
- 0000011 (ld) or 0100011 (sb) -> MEMADDR
- 0110011 -> EXEC
- 0010011 -> EXECI
- 1100011 -> BRANCH
- any other opcode -> REQ-025.

REQ-015 In MEMADDR the block SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUop = 00, then go to MEMRD for ld or MEMWR for sb.
REQ-016 In MEMRD the block SHALL drive MemRead = 1, IorD = 1, and hold until mem_ready = 1, then go to MEMWB.
REQ-017 In MEMWB the block SHALL drive RegWrite = 1, MemtoReg = 1, then go to FETCH.
REQ-018 In MEMWR the block SHALL drive MemWrite = 1, IorD = 1, and hold until mem_ready = 1, then go to FETCH.
REQ-019 EXEC SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUop = 10. EXECI SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUop = 11. Both go to ALUWB.
REQ-020 In ALUWB the block SHALL drive RegWrite = 1, MemtoReg = 0, then go to FETCH.
REQ-021 In BRANCH the block SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUop = 01, PCWriteCond = 1, PCSource = 1, then go to FETCH.
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 instr_count SHALL increment by 1 on each edge leaving MEMWB, ALUWB or BRANCH, and on each edge leaving MEMWR with mem_ready = 1. It wraps 0xFFFF -> 0x0000.
REQ-024 Instruction latency SHALL be, with mem_ready tied to 1:
- ld = 5 cycles
- sb = 4 cycles
- R-type / I-type = 4 cycles
- beq = 3 cycles.
REQ-025 An illegal opcode in DECODE SHALL be handled per REQ-030/REQ-031 and SHALL NOT increment instr_count.

Reset
REQ-026 With reset = 1 at a rising edge, the block SHALL set state = FETCH and instr_count = 0, and clear illegal; this applies in any state, including mid-access.
REQ-027 While reset = 1, the block SHALL force every strobe and select output to 0.
REQ-028 The first cycle after reset deasserts SHALL be FETCH with MemRead = 1.

Configuration
REQ-029 The block SHALL use the macro ILLEGAL_TRAP_EN.
REQ-030 With ILLEGAL_TRAP_EN defined: an illegal opcode SHALL move DECODE -> TRAP. In TRAP, all strobes are 0, illegal = 1, and the block stays in TRAP until reset.
REQ-031 With ILLEGAL_TRAP_EN undefined: an illegal opcode SHALL move DECODE -> FETCH (treated as a NOP), TRAP is unreachable, and illegal = 0.

Verification
REQ-032 The bench SHALL cover: ld (0000011), mem_ready = 1 -> states 0,1,2,3,4,0; RegWrite = 1 and MemtoReg = 1 only in state 4; instr_count 0 -> 1.
REQ-033 The bench SHALL cover: sb (0100011), mem_ready low for 3 cycles in MEMWR -> state = 5 held 4 cycles with MemWrite = 1; no count change until mem_ready = 1.
REQ-034 The bench SHALL cover: beq (1100011) -> state 8 with ALUop = 01, PCWriteCond = 1, PCSource = 1; back in FETCH after 3 cycles total.
REQ-035 The bench SHALL cover: opcode 1111111 -> with ILLEGAL_TRAP_EN, state = 15 and illegal = 1 held for 10 cycles, released by reset; without it, state returns to 0 and instr_count is unchanged.
REQ-036 The bench SHALL cover: reset asserted in MEMRD -> next state = 0, instr_count = 0, all strobes 0 during reset.
REQ-037 The bench SHALL cover: preload instr_count = 0xFFFF via 65535 R-type instructions, then one more -> instr_count = 0x0000.
